// File: rtl/contador_checker.sv
// Sequence checker for the contador up/down counter family: predicts each next
// count from the previous sample and controls, locks on, and counts mismatches.
module contador_checker #(
  parameter int WIDTH      = 8,
  parameter int ERR_WIDTH  = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 act,
  input  logic                 updown,
  input  logic [WIDTH-1:0]     cnt_in,
  output logic [WIDTH-1:0]     expected,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  // state  | meaning
  // IDLE   | history not yet valid, no compare
  // SYNC   | counting consecutive matches toward lock
  // LOCKED | tracking; a mismatch is reported and counted
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int LC     = (LOCK_COUNT < 1) ? 1 : LOCK_COUNT;
  localparam int GOOD_W = $clog2(LC + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LC - 1);

  logic [WIDTH-1:0]     prev_q;
  logic                 act_q;
  logic                 ud_q;
  logic [1:0]           state_q, state_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic                 err_q, err_d;
  logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 match;

  always_comb begin
    expected = prev_q;
    if (act_q) begin
      if (ud_q) expected = prev_q + WIDTH'(1);
      else      expected = prev_q - WIDTH'(1);
    end
  end

  assign match = (cnt_in == expected);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      state_d   = IDLE;
      good_d    = '0;
      err_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SYNC;
          good_d  = '0;
        end
        SYNC: begin
          if (match) begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_d   = 1'b1;
            state_d = SYNC;
            good_d  = '0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  // History loads every edge regardless of state or clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      act_q     <= 1'b0;
      ud_q      <= 1'b0;
      state_q   <= IDLE;
      good_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      prev_q    <= cnt_in;
      act_q     <= act;
      ud_q      <= updown;
      state_q   <= state_d;
      good_q    <= good_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_contador_checker.sv
// Scoreboard bench for contador_checker: a driver pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_contador_checker;

  localparam int WIDTH      = 8;
  localparam int ERR_WIDTH  = 2;
  localparam int LOCK_COUNT = 2;
  localparam int ERR_MAX    = (1 << ERR_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 clr = 1'b0;
  logic                 act = 1'b0;
  logic                 updown = 1'b0;
  logic [WIDTH-1:0]     cnt_in = '0;
  logic [WIDTH-1:0]     expected;
  logic                 locked;
  logic                 err;
  logic [ERR_WIDTH-1:0] err_count;

  contador_checker #(.WIDTH(WIDTH), .ERR_WIDTH(ERR_WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk(clk), .reset(reset), .clr(clr), .act(act), .updown(updown),
    .cnt_in(cnt_in), .expected(expected), .locked(locked), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_v;
    bit locked;
    bit err;
    int errc;
  } obs_t;

  obs_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: last sample, the controls it came with, and lock progress.
  int m_prev, m_run, m_errc;
  bit m_act, m_ud, m_valid, m_locked;

  function automatic int predict();
    int p;
    p = m_prev;
    if (m_act) p = m_ud ? m_prev + 1 : m_prev - 1;
    return (p % 256 + 256) % 256;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_act = 0; m_ud = 0;
    m_valid = 0; m_locked = 0; m_run = 0; m_errc = 0;
  endtask

  task automatic check(string name, int act_v, int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic check_zero(string name);
    check({name, ".locked"}, int'(locked), 0);
    check({name, ".err"}, int'(err), 0);
    check({name, ".err_count"}, int'(err_count), 0);
    check({name, ".expected"}, int'(expected), 0);
  endtask

  // One clock of stimulus; also releases reset if it was held.
  task automatic step(bit a, bit u, int c, bit cl);
    obs_t o;
    bit is_match, e;
    @(negedge clk);
    reset = 1'b1;
    act = a; updown = u; cnt_in = WIDTH'(c); clr = cl;
    is_match = (c == predict());
    e = 0;
    if (cl) begin
      m_valid = 0; m_locked = 0; m_run = 0; m_errc = 0;
    end else if (!m_valid) begin
      m_valid = 1; m_run = 0;
    end else if (!m_locked) begin
      m_run = is_match ? m_run + 1 : 0;
      if (m_run >= LOCK_COUNT) begin
        m_locked = 1; m_run = 0;
      end
    end else if (!is_match) begin
      e = 1; m_locked = 0; m_run = 0;
      if (m_errc < ERR_MAX) m_errc++;
    end
    m_prev = c; m_act = a; m_ud = u;
    o.exp_v = predict(); o.locked = m_locked; o.err = e; o.errc = m_errc;
    sb_q.push_back(o);
  endtask

  task automatic follow(int n, bit a, bit u);
    for (int i = 0; i < n; i++) step(a, u, predict(), 1'b0);
  endtask

  initial begin : monitor
    obs_t o;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        o = sb_q.pop_front();
        check("expected", int'(expected), o.exp_v);
        check("locked", int'(locked), int'(o.locked));
        check("err", int'(err), int'(o.err));
        check("err_count", int'(err_count), o.errc);
      end
    end
  end

  initial begin : driver
    model_reset();
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      act = 1'($urandom); updown = 1'($urandom);
      cnt_in = WIDTH'($urandom); clr = 1'($urandom);
      #1 check_zero("reset_hold");
    end

    // Up lock: 10,11,12,13.
    step(1, 1, 10, 0);
    step(1, 1, 11, 0);
    step(1, 1, 12, 0);
    step(1, 1, 13, 0);

    // Wrap up through 255->0, then down through 0->255.
    step(1, 1, 252, 1);
    follow(6, 1, 1);
    follow(5, 1, 0);

    // Hold at 42, then hold violation 42->43.
    step(0, 0, 42, 1);
    follow(5, 0, 0);
    step(0, 0, 43, 0);
    follow(4, 1, 1);

    // Glitch: 19,20,21 then 99, then 100,101.. relocks.
    step(1, 1, 18, 1);
    follow(3, 1, 1);
    step(1, 1, 99, 0);
    follow(5, 1, 1);

    // Saturation: five lock/mismatch rounds with err_count capped at 3.
    step(1, 1, 5, 1);
    for (int r = 0; r < 5; r++) begin
      follow(3, 1, 1);
      step(1, 1, (predict() + 7) % 256, 0);
    end
    follow(2, 1, 1);
    step(1, 1, predict(), 1);
    follow(4, 1, 0);

    // Async reset mid-lock with an err pulse in flight.
    step(1, 0, (predict() + 3) % 256, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("reset_after_edge");

    // Random phase: mostly a well-behaved counter, with glitches and clears.
    for (int i = 0; i < 400; i++) begin
      bit a, u;
      int r;
      a = ($urandom_range(0, 9) != 0);
      u = 1'($urandom);
      r = $urandom_range(0, 99);
      if (r < 6)       step(a, u, $urandom_range(0, 255), 0);
      else if (r < 8)  step(a, u, predict(), 1);
      else             step(a, u, predict(), 0);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_checker.md
# contador_checker

Sequence checker for the up/down counter family (`contador`, `contador2`). It samples the counter's `out` bus together with the same `act` and `updown` controls that drive the counter, and predicts each next value. It locks onto the sequence and flags every step that breaks the expected count. It sits beside the counter as the consuming end of its count interface, for on-chip self-check and bench scoreboarding.

## Interface
- `WIDTH`, 8, width of the count bus under check.
- `ERR_WIDTH`, 8, width of the saturating error counter.
- `LOCK_COUNT`, 2, consecutive matching samples required to enter LOCKED (minimum 1).

- `clk`  in  1  rising-edge clock, same clock as the counter.
- `reset`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear: FSM to IDLE, `err_count` to 0.
- `act`  in  1  counter enable, as driven to the counter.
- `updown`  in  1  count direction as driven to the counter: 1 = up, 0 = down.
- `cnt_in`  in  WIDTH  counter output under check.
- `expected`  out  WIDTH  predicted value of `cnt_in` for the current cycle.
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  one-cycle pulse per detected mismatch while locked.
- `err_count`  out  ERR_WIDTH  total mismatches since reset/clr; saturates.

## Operation
**History registers**
- Updated on every edge, in all states: `prev <= cnt_in`, `act_q <= act`, `ud_q <= updown`.
- `expected` is combinational from these registers only:
  - `act_q = 0`: `prev`.
  - `act_q = 1`, `ud_q = 1`: `prev + 1`.
  - `act_q = 1`, `ud_q = 0`: `prev - 1`.
- All arithmetic is modulo 2^WIDTH: 255+1 -> 0 and 0-1 -> 255 for WIDTH=8. Wrap is never an error.
- `match = (cnt_in == expected)`.

**FSM states:** IDLE, SYNC, LOCKED. `good` is a match counter sized for `LOCK_COUNT`.
- IDLE: the next edge moves to SYNC with `good = 0`. No compare is made, because the history is not yet valid.
- SYNC:
  - On `match`: `good++`. When this match is the `LOCK_COUNT`-th consecutive one, go to LOCKED.
  - On mismatch: `good = 0`, stay in SYNC. No `err`, no count.
- LOCKED:
  - On `match`: stay.
  - On mismatch: `err` pulses, `err_count` increments unless already at 2^ERR_WIDTH-1, and the FSM returns to SYNC with `good = 0`.
- `clr` = 1 at an edge overrides everything: state goes to IDLE, `good = 0`, `err_count = 0`, `err = 0`. History registers still load.
- A counter reset seen as a jump to 0 while locked is a mismatch and is counted. Hosts assert `clr` alongside the counter's reset to avoid this.

**Reset (`reset` low, asynchronous)**
- State IDLE, `good = 0`.
- `prev = 0`, `act_q = 0`, `ud_q = 0`, so `expected = 0`.
- `locked = 0`, `err = 0`, `err_count = 0`.
- Reset release is synchronous to `clk` on the host side.

## Timing
- Compare uses `cnt_in` as present before edge k, against history captured at edge k-1.
- `err` and `err_count` are registered.
  - A mismatch detected at edge k drives `err` high from edge k to edge k+1, exactly one cycle.
  - `err_count` shows the new value after edge k.
- `locked` is registered: it rises after the edge of the `LOCK_COUNT`-th match and falls after the edge of the mismatch.
- Back-to-back mismatches: only the first, taken in LOCKED, pulses `err`. The following ones occur in SYNC and are silent.
- Changing `updown` or `act` is legal on any cycle. Prediction always uses the values sampled at the previous edge, matching the counter's registered update.
- Asynchronous reset mid-lock: outputs go to reset values immediately. Any `err` pulse in flight is dropped.

## Test plan
- **Reset:** hold `reset` = 0 with random inputs -> `locked` = 0, `err` = 0, `err_count` = 0, `expected` = 0. Release -> IDLE, then SYNC after 1 edge.
- **Up lock:** `act` = 1, `updown` = 1, `cnt_in` 10, 11, 12, 13 on successive edges with `LOCK_COUNT` = 2 -> `locked` rises after the edge sampling 12. `err` never asserts.
- **Wrap and hold:**
  - Locked up through 254, 255, 0, 1 -> no `err`.
  - Switch `updown` to 0 through 1, 0, 255 -> no `err`.
  - `act` = 0 with `cnt_in` held at 42 -> stays locked.
- **Glitch:** locked counting up 20, 21, then 99 -> `err` high for exactly 1 cycle, `err_count` = 1, `locked` = 0. Then 100, 101 -> relocked, no further `err`.
- **Hold violation:** locked with `act` = 0, `cnt_in` moves 42 -> 43 -> `err` pulse, `err_count` increments.
- **Saturation and clear:**
  - `ERR_WIDTH` = 2, force 5 lock/mismatch cycles -> `err_count` stops at 3 while `err` still pulses each time.
  - Assert `clr` -> `err_count` = 0, `locked` = 0, state IDLE.
  - Assert `reset` low mid-lock -> all outputs 0 without waiting for a clock edge.
